// File: rtl/ll_release_engine_pkg.sv
// Shared linked-list types for the reassembly drain stage: node entry layout,
// release record and the wrap-safe sequence comparison.
package ll_release_engine_pkg;

    localparam int LL_AWIDTH  = 10;
    localparam int PKT_AWIDTH = 12;
    localparam int TAG_W      = 16;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [LL_AWIDTH-1:0]  next;
        logic [31:0]           seq;
        logic [15:0]           len;
        logic [4:0]            flits;
        logic [55:0]           last_7_bytes;
        logic [PKT_AWIDTH-1:0] pktID;
    } entry_t;

    typedef struct packed {
        logic [PKT_AWIDTH-1:0] pktID;
        logic [4:0]            flits;
        logic [15:0]           len;
        logic [55:0]           last_7_bytes;
        logic                  drop;
        logic [TAG_W-1:0]      tag;
    } rel_rec_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_HEAD,
        ST_EVAL,
        ST_EMIT,
        ST_FREE,
        ST_ALLOC,
        ST_WAIT_ALLOC,
        ST_RESP
    } state_e;

    // Distance of a node's seq from the expected seq; the sign survives 2^32 wrap.
    function automatic logic signed [31:0] seq_delta(input logic [31:0] seq,
                                                     input logic [31:0] expected);
        return $signed(seq - expected);
    endfunction

endpackage

// File: rtl/ll_release_engine.sv
// Drains in-order packets from the head of a flow's out-of-order list, freeing
// each released node and reporting the new head pointer and expected seq.
module ll_release_engine
    import ll_release_engine_pkg::*;
#(
    parameter int MAX_RELEASE = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LL_AWIDTH-1:0]  req_pointer,
    input  logic [31:0]           req_seq,
    input  logic [TAG_W-1:0]      req_tag,

    output logic                  rsp_valid,
    output logic [LL_AWIDTH-1:0]  rsp_pointer,
    output logic [31:0]           rsp_seq,
    output logic                  rsp_empty,
    output logic                  rsp_more,
    output logic [TAG_W-1:0]      rsp_tag,

    output logic                  rel_valid,
    input  logic                  rel_ready,
    output logic [PKT_AWIDTH-1:0] rel_pktID,
    output logic [4:0]            rel_flits,
    output logic [15:0]           rel_len,
    output logic [55:0]           rel_last_7_bytes,
    output logic                  rel_drop,
    output logic [TAG_W-1:0]      rel_tag,

    input  logic                  ll_busy,
    output logic [LL_AWIDTH-1:0]  ll_pointer,
    output logic                  load_head,
    input  entry_t                head_out,
    input  logic                  head_out_valid,
    output logic                  store_head,
    output entry_t                head_in,
    output logic [LL_AWIDTH-1:0]  head_wr_addr,
    output logic                  load_empty_pointer,
    input  logic [LL_AWIDTH-1:0]  empty_pointer,
    input  logic                  empty_pointer_valid
);

    localparam int CNT_W = $clog2(MAX_RELEASE + 1);

    state_e               state_q;
    logic [LL_AWIDTH-1:0] ptr_q;
    logic [31:0]          exp_q;
    logic [TAG_W-1:0]     tag_q;
    logic [CNT_W-1:0]     cnt_q;
    entry_t               head_q;
    rel_rec_t             rel_q;
    logic                 rel_valid_q;
    logic                 rsp_valid_q;
    logic                 rsp_empty_q;
    logic                 rsp_more_q;
    logic                 req_ready_q;

    logic signed [31:0]   head_delta;
    logic [31:0]          exp_d;
    logic [CNT_W-1:0]     cnt_d;
    rel_rec_t             rel_d;
    logic                 ll_free;

    assign head_delta = seq_delta(head_q.seq, exp_q);
    assign exp_d      = exp_q + {16'd0, head_q.len};
    assign cnt_d      = cnt_q + CNT_W'(1);

    always_comb begin
        rel_d              = '0;
        rel_d.pktID        = head_q.pktID;
        rel_d.flits        = head_q.flits;
        rel_d.len          = head_q.len;
        rel_d.last_7_bytes = head_q.last_7_bytes;
        rel_d.drop         = head_delta[31];
        rel_d.tag          = tag_q;
    end

    // LL commands gate on the live busy input so none is ever presented while busy.
    assign ll_free            = !rst && !ll_busy;
    assign load_head          = ll_free && (state_q == ST_LOAD);
    assign store_head         = ll_free && (state_q == ST_FREE);
    assign load_empty_pointer = ll_free && (state_q == ST_ALLOC);
    assign ll_pointer         = ptr_q;
    assign head_wr_addr       = ptr_q;
    assign head_in            = '0;

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_pointer      = ptr_q;
    assign rsp_seq          = exp_q;
    assign rsp_empty        = rsp_empty_q;
    assign rsp_more         = rsp_more_q;
    assign rsp_tag          = tag_q;
    assign rel_valid        = rel_valid_q;
    assign rel_pktID        = rel_q.pktID;
    assign rel_flits        = rel_q.flits;
    assign rel_len          = rel_q.len;
    assign rel_last_7_bytes = rel_q.last_7_bytes;
    assign rel_drop         = rel_q.drop;
    assign rel_tag          = rel_q.tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            exp_q       <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            head_q      <= '0;
            rel_q       <= '0;
            rel_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_empty_q <= 1'b0;
            rsp_more_q  <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        ptr_q       <= req_pointer;
                        exp_q       <= req_seq;
                        tag_q       <= req_tag;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!ll_busy) state_q <= ST_WAIT_HEAD;
                end
                ST_WAIT_HEAD: begin
                    if (head_out_valid) begin
                        head_q  <= head_out;
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (!head_q.valid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_empty_q <= 1'b1;
                        rsp_more_q  <= 1'b0;
                        state_q     <= ST_RESP;
                    end else if (head_delta == 32'sd0) begin
                        if (cnt_q == CNT_W'(MAX_RELEASE)) begin
                            rsp_valid_q <= 1'b1;
                            rsp_empty_q <= 1'b0;
                            rsp_more_q  <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            exp_q       <= exp_d;
                            rel_q       <= rel_d;
                            rel_valid_q <= 1'b1;
                            state_q     <= ST_EMIT;
                        end
                    end else if (!head_delta[31]) begin
                        rsp_valid_q <= 1'b1;
                        rsp_empty_q <= 1'b0;
                        rsp_more_q  <= 1'b0;
                        state_q     <= ST_RESP;
                    end else begin
                        rel_q       <= rel_d;
                        rel_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rel_ready) begin
                        rel_valid_q <= 1'b0;
                        state_q     <= ST_FREE;
                    end
                end
                ST_FREE: begin
                    if (!ll_busy) begin
                        cnt_q <= cnt_d;
                        if (head_q.last) begin
                            state_q <= ST_ALLOC;
                        end else begin
                            ptr_q   <= head_q.next;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_ALLOC: begin
                    if (!ll_busy) state_q <= ST_WAIT_ALLOC;
                end
                ST_WAIT_ALLOC: begin
                    if (empty_pointer_valid) begin
                        ptr_q       <= empty_pointer;
                        rsp_valid_q <= 1'b1;
                        rsp_empty_q <= 1'b1;
                        rsp_more_q  <= 1'b0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
